// File: rtl/decoder_2to4_buf.sv
// Purpose: buffered binary-code to one-hot decoder between two valid/ready handshakes.
// Latency: a code pushed at edge t is presented on Do from edge t (no same-cycle pass-through).
// Backpressure: in_ready drops when the FIFO is full or En is low; out_ready low holds the head.
module decoder_2to4_buf #(
    parameter int CODE_W = 2,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   En,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CODE_W-1:0]      Din,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [(2**CODE_W)-1:0] Do,
    output logic [CNT_W-1:0]       dec_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [CODE_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [CODE_W-1:0] head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // Pointer MSB toggles on each wrap, so equal low bits with differing MSBs means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Both handshakes are held off while reset is asserted so nothing moves in that cycle.
    assign in_ready  = En & ~full & ~rst;
    assign out_valid = En & ~empty & ~rst;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign head      = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= Din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            dec_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + (AW+1)'(1);
                dec_cnt <= dec_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        Do = '0;
        if (out_valid) begin
            Do[head] = 1'b1;
        end
    end

endmodule
